redun_iter_ctrl: RTL and testbench
==================================

// Module: redun_iter_ctrl
// PURPOSE
// - Host-side initiator for the squaring wrapper: drives i_start/i_sq_in/i_reset_mont, consumes o_sq_out/o_valid/o_ready.
// - Runs a VDF job: loads a seed, issues one square per iteration, feeds each result back as the next operand.
// - Returns the final value after the requested iteration count. Lives in the i_clk domain next to the wrapper.
// PARAMETERS
// - ITER_W       64    width of iteration count and counter
// - TIMEOUT_CYC  4096  max cycles from issue to result (used only with REDUN_ITER_TIMEOUT_EN)
// PORTS
// - i_clk          in   1         system clock (same clock as the wrapper host side)
// - i_reset        in   1         synchronous, active-high reset
// - i_start        in   1         job start pulse; sampled only in IDLE
// - i_sq_init      in   redun0_t  seed value, captured with i_start
// - i_iter         in   ITER_W    number of squarings, captured with i_start
// - o_busy         out  1         high from accepted start until o_done/o_err
// - o_done         out  1         one-cycle pulse: job complete, o_sq_final valid
// - o_sq_final     out  redun0_t  final result; held until next accepted start
// - o_iter_cnt     out  ITER_W    completed iterations of current/last job
// - o_err          out  1         sticky protocol/timeout error; cleared by accepted start or reset
// - o_mont_reset   out  1         to wrapper i_reset_mont
// - o_mont_start   out  1         to wrapper i_start; one-cycle issue pulse
// - o_mont_sq      out  redun0_t  to wrapper i_sq_in; valid with o_mont_start
// - i_mont_sq      in   redun0_t  from wrapper o_sq_out
// - i_mont_valid   in   1         from wrapper o_valid
// - i_mont_ready   in   1         from wrapper o_ready
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; operand, counter and target registers cleared.
// - States: IDLE, RST_CORE, WAIT_RDY, ISSUE, WAIT_RES, DONE, ERR.
// - IDLE: i_start -> latch i_sq_init into cur, i_iter into target, clear count and o_err, o_busy=1, go RST_CORE.
//   i_start while not IDLE is ignored (no effect, no error).
// - RST_CORE: o_mont_reset=1 for exactly 4 cycles -> WAIT_RDY.
// - WAIT_RDY: wait for i_mont_ready=1; if target==0 go DONE directly (final = seed), else go ISSUE.
// - ISSUE: o_mont_start=1, o_mont_sq=cur for exactly one cycle -> WAIT_RES. Exactly one square outstanding.
// - WAIT_RES: on i_mont_valid: cur<=i_mont_sq, count<=count+1; if count+1==target -> DONE else ISSUE.
//   Next issue is the cycle after valid (1-cycle turnaround).
// - DONE: o_sq_final<=cur, o_done=1 one cycle, o_busy=0 -> IDLE.
// - i_mont_valid outside WAIT_RES: data discarded, o_err=1, go ERR (if busy) else stay IDLE.
// - i_mont_ready falling while in ISSUE/WAIT_RES: abort -> ERR.
// - ERR: o_busy=0, o_err=1 held; o_sq_final unchanged; -> IDLE next cycle (new start accepted).
// - count never wraps: target==2^ITER_W-1 terminates normally; no modular arithmetic on data (pass-through).
// - i_reset mid-job: immediate return to reset state; no o_done.
// CONFIGURATION
// - REDUN_ITER_TIMEOUT_EN defined: watchdog counter reloaded on each issue; if WAIT_RES persists
//   TIMEOUT_CYC cycles without i_mont_valid -> o_err=1, go ERR.
// - Not defined: no watchdog logic; WAIT_RES waits indefinitely; TIMEOUT_CYC unused.
// STRUCTURE
// - redun_mont_pkg: redun0_t, NUM_WRDS (existing); add iter_state_t enum and ITER_W default constant.
// - Single module, no sub-modules; watchdog counter inline under the macro.
// TESTING (bench models wrapper: result = operand+1 per word, fixed 10-cycle latency, ready after reset)
// - seed word0=3, i_iter=0 -> no o_mont_start; o_done with o_sq_final word0=3, o_iter_cnt=0.
// - seed word0=3, i_iter=5 -> exactly 5 o_mont_start pulses, o_done once, final word0=8, o_iter_cnt=5.
// - i_start pulsed again mid-job of i_iter=5 -> ignored; result still 8, single o_done.
// - spurious i_mont_valid in IDLE then during ISSUE of busy job -> o_err=1, job ends without o_done.
// - i_reset asserted at iteration 3 of 5 -> all outputs 0 next cycle; fresh job i_iter=2, seed 0 -> final 2.
// - REDUN_ITER_TIMEOUT_EN, TIMEOUT_CYC=16, model never returns -> o_err=1 16 cycles after issue, o_busy=0.

Source files
------------

// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant-form Montgomery squaring path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package redun_mont_pkg;

    // Redundant operand: NUM_WRDS words of WRD_W bits each.
    localparam int NUM_WRDS = 4;
    localparam int WRD_W    = 16;

    typedef logic [NUM_WRDS-1:0][WRD_W-1:0] redun0_t;

    // Default width of the iteration target and completed-iteration counter.
    localparam int ITER_W_DEF = 64;

    // Number of cycles the squaring core is held in reset at job start.
    localparam int RST_CORE_CYC = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_CORE = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } iter_state_t;

endpackage

// File: rtl/redun_iter_ctrl.sv
// VDF iteration controller: resets the squaring core, then squares a seed i_iter times, feeding each result back.
// Latency: 4 core-reset cycles + 1 ready cycle + per iteration (1 issue + core latency) + 1 done cycle.
// Backpressure: waits for i_mont_ready before the first issue; exactly one square outstanding; ready drop mid-job aborts.
//
// Ports: i_clk/i_reset (sync, active high); job interface i_start/i_sq_init/i_iter -> o_busy/o_done/o_sq_final/
// o_iter_cnt/o_err; core interface o_mont_reset/o_mont_start/o_mont_sq -> i_mont_sq/i_mont_valid/i_mont_ready.
// Optional macro REDUN_ITER_TIMEOUT_EN: adds a watchdog that errors out if a result takes TIMEOUT_CYC cycles.
module redun_iter_ctrl
    import redun_mont_pkg::*;
#(
    parameter int ITER_W      = ITER_W_DEF,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  redun0_t           i_sq_init,
    input  logic [ITER_W-1:0] i_iter,
    output logic              o_busy,
    output logic              o_done,
    output redun0_t           o_sq_final,
    output logic [ITER_W-1:0] o_iter_cnt,
    output logic              o_err,
    output logic              o_mont_reset,
    output logic              o_mont_start,
    output redun0_t           o_mont_sq,
    input  redun0_t           i_mont_sq,
    input  logic              i_mont_valid,
    input  logic              i_mont_ready
);

    iter_state_t       state_q, state_d;
    redun0_t           cur_q;
    redun0_t           final_q;
    logic [ITER_W-1:0] target_q;
    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] count_inc;
    logic [1:0]        rst_cnt_q;
    logic              err_q;

    // Control strobes decoded by the next-state logic.
    logic start_acc;
    logic take_res;
    logic set_err;
    logic ld_final_cur;
    logic ld_final_res;
    logic wd_expired;

    // count < target always holds while a square is outstanding, so this never wraps.
    assign count_inc = count_q + {{(ITER_W-1){1'b0}}, 1'b1};

`ifdef REDUN_ITER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    // Counts cycles since the last issue: 1 in the first WAIT_RES cycle, so expiry at
    // TIMEOUT_CYC-1 makes o_err rise exactly TIMEOUT_CYC cycles after the issue cycle.
    logic [WD_W-1:0] wd_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wd_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wd_q <= WD_W'(1);
        end else if (state_q == ST_WAIT_RES) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign wd_expired = (state_q == ST_WAIT_RES) && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_acc    = 1'b0;
        take_res     = 1'b0;
        set_err      = 1'b0;
        ld_final_cur = 1'b0;
        ld_final_res = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A stray result while idle is flagged; it takes priority over a same-cycle start.
                if (i_mont_valid) begin
                    set_err = 1'b1;
                end else if (i_start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RST_CORE;
                end
            end
            ST_RST_CORE: begin
                if (i_mont_valid) begin
                    set_err = 1'b1;
                    state_d = ST_ERR;
                end else if (rst_cnt_q == 2'(RST_CORE_CYC - 1)) begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (i_mont_valid) begin
                    set_err = 1'b1;
                    state_d = ST_ERR;
                end else if (i_mont_ready) begin
                    if (target_q == '0) begin
                        ld_final_cur = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (i_mont_valid || !i_mont_ready) begin
                    set_err = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (!i_mont_ready) begin
                    set_err = 1'b1;
                    state_d = ST_ERR;
                end else if (i_mont_valid) begin
                    take_res = 1'b1;
                    if (count_inc == target_q) begin
                        ld_final_res = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (wd_expired) begin
                    set_err = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                set_err = i_mont_valid;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                set_err = i_mont_valid;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cur_q     <= '0;
            final_q   <= '0;
            target_q  <= '0;
            count_q   <= '0;
            rst_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (start_acc) begin
                cur_q     <= i_sq_init;
                target_q  <= i_iter;
                count_q   <= '0;
                rst_cnt_q <= '0;
                err_q     <= 1'b0;
            end
            if (state_q == ST_RST_CORE) begin
                rst_cnt_q <= rst_cnt_q + 2'd1;
            end
            if (take_res) begin
                cur_q   <= i_mont_sq;
                count_q <= count_inc;
            end
            // The final value is loaded on entry to DONE so it is valid alongside o_done.
            if (ld_final_cur) begin
                final_q <= cur_q;
            end
            if (ld_final_res) begin
                final_q <= i_mont_sq;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_busy       = (state_q == ST_RST_CORE) || (state_q == ST_WAIT_RDY) ||
                          (state_q == ST_ISSUE)    || (state_q == ST_WAIT_RES);
    assign o_done       = (state_q == ST_DONE);
    assign o_sq_final   = final_q;
    assign o_iter_cnt   = count_q;
    assign o_err        = err_q;
    assign o_mont_reset = (state_q == ST_RST_CORE);
    assign o_mont_start = (state_q == ST_ISSUE);
    assign o_mont_sq    = (state_q == ST_ISSUE) ? cur_q : '0;

endmodule

// File: tb/tb_redun_iter_ctrl.sv
// Randomized self-checking bench for redun_iter_ctrl with a behavioural squaring-core model.
// Latency: core model returns operand+1 per word 10 cycles after each issue.
// Backpressure: core model deasserts ready while held in reset.
module tb_redun_iter_ctrl;
    import redun_mont_pkg::*;

    localparam int ITER_W = 64;
    localparam int TB_TO  = 16;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_start;
    redun0_t           i_sq_init;
    logic [ITER_W-1:0] i_iter;
    logic              o_busy;
    logic              o_done;
    redun0_t           o_sq_final;
    logic [ITER_W-1:0] o_iter_cnt;
    logic              o_err;
    logic              o_mont_reset;
    logic              o_mont_start;
    redun0_t           o_mont_sq;
    redun0_t           mont_sq;
    logic              mont_valid_m;
    logic              spur_valid;
    logic              mont_ready;

    redun_iter_ctrl #(.ITER_W(ITER_W), .TIMEOUT_CYC(TB_TO)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_sq_init   (i_sq_init),
        .i_iter      (i_iter),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sq_final  (o_sq_final),
        .o_iter_cnt  (o_iter_cnt),
        .o_err       (o_err),
        .o_mont_reset(o_mont_reset),
        .o_mont_start(o_mont_start),
        .o_mont_sq   (o_mont_sq),
        .i_mont_sq   (mont_sq),
        .i_mont_valid(mont_valid_m | spur_valid),
        .i_mont_ready(mont_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each iteration adds one to every word independently.
    function automatic redun0_t add_words(input redun0_t v, input int n);
        redun0_t r;
        for (int w = 0; w < NUM_WRDS; w++) begin
            r[w] = v[w] + WRD_W'(n);
        end
        return r;
    endfunction

    // Squaring-core model and output monitor, both on the falling edge.
    int      cyc = 0;
    int      n_issue = 0;
    int      n_done = 0;
    int      issue_cyc = 0;
    redun0_t done_val = '0;
    logic [ITER_W-1:0] done_cnt = '0;
    logic    pend = 1'b0;
    int      lat_left = 0;
    redun0_t op = '0;
    logic    never_return = 1'b0;

    initial begin
        mont_valid_m = 1'b0;
        mont_ready   = 1'b0;
        mont_sq      = '0;
    end

    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        mont_valid_m = 1'b0;
        if (i_reset || o_mont_reset) begin
            pend = 1'b0;
        end else if (pend) begin
            if (lat_left == 1) begin
                mont_valid_m = 1'b1;
                mont_sq      = add_words(op, 1);
                pend         = 1'b0;
            end else begin
                lat_left--;
            end
        end
        if (o_mont_start && !never_return) begin
            pend     = 1'b1;
            lat_left = 10;
            op       = o_mont_sq;
        end
        mont_ready = !o_mont_reset;
        if (o_mont_start) begin
            n_issue++;
            issue_cyc = cyc;
        end
        if (o_done) begin
            n_done++;
            done_val = o_sq_final;
            done_cnt = o_iter_cnt;
        end
    end

    task automatic pulse_start(input redun0_t seed, input logic [ITER_W-1:0] iter);
        i_start   = 1'b1;
        i_sq_init = seed;
        i_iter    = iter;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int d0);
        int k;
        k = 0;
        while (n_done == d0 && !o_err && k < 3000) begin
            @(negedge i_clk);
            k++;
        end
        if (k >= 3000) check_eq({tag, "_timeout"}, 1, 0);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic run_job(input string tag, input redun0_t seed, input logic [ITER_W-1:0] iter);
        int i0, d0;
        i0 = n_issue;
        d0 = n_done;
        pulse_start(seed, iter);
        wait_end(tag, d0);
        check_eq({tag, "_issues"}, n_issue - i0, iter);
        check_eq({tag, "_dones"}, n_done - d0, 1);
        check_eq({tag, "_final"}, done_val, add_words(seed, int'(iter)));
        check_eq({tag, "_held"}, o_sq_final, add_words(seed, int'(iter)));
        check_eq({tag, "_cnt"}, done_cnt, iter);
        check_eq({tag, "_err_busy"}, {o_err, o_busy}, 2'b00);
    endtask

    initial begin
        redun0_t seed;
        int      i0, d0, k;

        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_sq_init  = '0;
        i_iter     = '0;
        spur_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check_eq("rst_ctl", {o_busy, o_done, o_err, o_mont_reset, o_mont_start}, 5'b0);
        check_eq("rst_final", o_sq_final, 0);
        check_eq("rst_cnt", o_iter_cnt, 0);
        check_eq("rst_msq", o_mont_sq, 0);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        seed = '0;
        seed[0] = 16'd3;
        run_job("iter0", seed, 0);
        run_job("iter5", seed, 5);

        // Start pulsed mid-job must be ignored.
        i0 = n_issue;
        d0 = n_done;
        pulse_start(seed, 5);
        repeat (20) @(negedge i_clk);
        pulse_start({4{16'h0100}}, 1);
        wait_end("restart", d0);
        check_eq("restart_dones", n_done - d0, 1);
        check_eq("restart_issues", n_issue - i0, 5);
        check_eq("restart_final", done_val, add_words(seed, 5));

        // Spurious result while idle.
        spur_valid = 1'b1;
        @(negedge i_clk);
        spur_valid = 1'b0;
        @(negedge i_clk);
        check_eq("spur_idle_err", {o_err, o_busy}, 2'b10);

        // Spurious result during an issue aborts the job.
        d0 = n_done;
        pulse_start(seed, 5);
        check_eq("start_clears_err", {o_err, o_busy}, 2'b01);
        k = 0;
        while (!o_mont_start && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        spur_valid = 1'b1;
        @(negedge i_clk);
        spur_valid = 1'b0;
        @(negedge i_clk);
        check_eq("spur_issue_err", {o_err, o_busy}, 2'b10);
        repeat (15) @(negedge i_clk);
        check_eq("spur_issue_nodone", n_done - d0, 0);

        // Reset asserted at iteration 3 of 5.
        d0 = n_done;
        i0 = n_issue;
        pulse_start(seed, 5);
        k = 0;
        while (n_issue - i0 < 3 && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        i_reset = 1'b1;
        @(negedge i_clk);
        check_eq("midrst_ctl", {o_busy, o_done, o_err, o_mont_reset, o_mont_start}, 5'b0);
        check_eq("midrst_final", o_sq_final, 0);
        check_eq("midrst_cnt", o_iter_cnt, 0);
        i_reset = 1'b0;
        repeat (15) @(negedge i_clk);
        check_eq("midrst_nodone", n_done - d0, 0);
        run_job("after_rst", '0, 2);

        // Randomized jobs against the reference model.
        for (int j = 0; j < 6; j++) begin
            seed = {$urandom, $urandom};
            run_job("rand", seed, ITER_W'($urandom_range(0, 7)));
        end

`ifdef REDUN_ITER_TIMEOUT_EN
        never_return = 1'b1;
        d0 = n_done;
        pulse_start(seed, 3);
        k = 0;
        while (!o_mont_start && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        k = 0;
        while (!o_err && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check_eq("wd_delay", cyc - issue_cyc, TB_TO);
        check_eq("wd_err_busy", {o_err, o_busy}, 2'b10);
        check_eq("wd_nodone", n_done - d0, 0);
        never_return = 1'b0;
        repeat (3) @(negedge i_clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
